// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder; the single slice shared across all bit positions.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one fa_cell stepped LSB first through a carry register.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' input for a - b (two's complement).
import serial_add_pkg::*;

module serial_add_ctrl #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_sh_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             s_bit, c_bit;
    logic             last;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is a + ~b + 1, so cin is replaced by a forced carry-in.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    fa_cell u_slice (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (s_bit),
        .co (c_bit)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    // A one-bit register has no upper part to shift in from.
    generate
        if (WIDTH == 1) begin : g_sum_narrow
            assign sum_sh_next = s_bit;
        end else begin : g_sum_wide
            assign sum_sh_next = {s_bit, sum_sh[WIDTH-1:1]};
        end
    endgenerate

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // NOTE: every datapath register is cleared on reset so an aborted operation leaves no residue.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b_load;
                        carry  <= carry_load;
                        cnt    <= '0;
                        sum_sh <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_sh_next;
                    carry  <= c_bit;
                    cnt    <= last ? '0 : cnt + 1'b1;
                    // Result registers are written only on the edge that enters DONE.
                    if (last) begin
                        sum  <= sum_sh_next;
                        cout <= c_bit;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    logic         fa_a, fa_b, fa_ci, fa_s, fa_co;

    int vectors = 0;
    int errors  = 0;

    logic [W-1:0] prev_sum;
    logic         prev_cout;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    fa_cell u_fa (
        .a  (fa_a),
        .b  (fa_b),
        .ci (fa_ci),
        .s  (fa_s),
        .co (fa_co)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: (W+1)-bit arithmetic sum; subtraction as a plus two's complement of b.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
        logic [W:0] r;
        if (s) r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        else   r = {1'b0, x} + {1'b0, y} + (W+1)'(c);
        return r;
    endfunction

    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic c, input logic s);
        @(posedge clk);
        #1;
        start = 1'b1; a = x; b = y; cin = c; sub = s;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic s, input bit glitch);
        logic [W:0] exp;
        logic       eff_sub;
        int         lat, busy_cnt;
        bit         seen;
`ifdef SERIAL_ADD_SUB_EN
        eff_sub = s;
`else
        eff_sub = 1'b0;
`endif
        exp      = model(x, y, c, eff_sub);
        lat      = -1;
        busy_cnt = 0;
        seen     = 0;
        start_op(x, y, c, s);
        for (int k = 0; k < 4 * W; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("sum_held_in_run", sum, prev_sum);
                check("cout_held_in_run", cout, prev_cout);
            end
            if (glitch && k == 3) begin
                start = 1'b1; a = '1; b = '1;
            end else if (glitch && k == 4) begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1;
                lat  = k;
                break;
            end
            if (busy) busy_cnt++;
        end
        check("done_seen", seen, 1);
        check("latency", lat, W);
        check("busy_cycles", busy_cnt, W);
        check("busy_in_done", busy, 0);
        check("sum", sum, exp[W-1:0]);
        check("cout", cout, exp[W]);
        @(negedge clk);
        check("done_single", done, 0);
        check("sum_held_idle", sum, exp[W-1:0]);
        prev_sum  = exp[W-1:0];
        prev_cout = exp[W];
    endtask

    initial begin
        int pulses[$];
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        fa_a = 0; fa_b = 0; fa_ci = 0;

        // Full-adder slice exhaustively.
        for (int i = 0; i < 8; i++) begin
            int ones;
            {fa_a, fa_b, fa_ci} = 3'(i);
            #1;
            ones = int'(fa_a) + int'(fa_b) + int'(fa_ci);
            check("fa_s", fa_s, ones % 2);
            check("fa_co", fa_co, (ones >= 2) ? 1 : 0);
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        rst = 1'b0;
        prev_sum = '0; prev_cout = 1'b0;

        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'hAA, 8'h55, 1'b1, 1'b0, 0);

        // Start held high: one done pulse every W+2 cycles.
        @(posedge clk);
        #1;
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1; sub = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 3 * (W + 2); k++) begin
            @(negedge clk);
            if (done) begin
                pulses.push_back(k);
                check("held_sum", sum, 8'h00);
                check("held_cout", cout, 1);
            end
        end
        start = 1'b0;
        check("held_pulses", pulses.size(), 3);
        if (pulses.size() == 3) begin
            check("held_first", pulses[0], W);
            check("held_gap1", pulses[1] - pulses[0], W + 2);
            check("held_gap2", pulses[2] - pulses[1], W + 2);
        end
        prev_sum = 8'h00; prev_cout = 1'b1;
        repeat (2) @(negedge clk);

        // Start during RUN is ignored.
        run_op(8'h03, 8'h04, 1'b0, 1'b0, 1);

        // Reset in the 4th RUN cycle aborts.
        start_op(8'h21, 8'h10, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        rst = 1'b0;
        begin
            int dones = 0;
            for (int k = 0; k < W + 2; k++) begin
                @(negedge clk);
                if (done) dones++;
            end
            check("abort_no_done", dones, 0);
        end
        prev_sum = '0; prev_cout = 1'b0;
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADD_SUB_EN
        run_op(8'h05, 8'h07, 1'b0, 1'b1, 0);
        run_op(8'h07, 8'h05, 1'b1, 1'b1, 0);
`endif

        // Randomized operations with random idle gaps.
        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] x, y;
            logic         c, s;
            x = W'($urandom);
            y = W'($urandom);
            c = 1'($urandom);
            s = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(x, y, c, s, ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller that time-shares a single one-bit full-adder slice across a WIDTH-bit addition, least significant bit first.
- Captures operands on a start request and steps the slice once per cycle through a carry register.
- Assembles the sum in a shift register and signals completion with a one-cycle done pulse.
- Replaces a WIDTH-slice ripple adder where area matters more than latency.

Parameters:
WIDTH, 8, operand and sum width in bits (≥1); counter width is derived internally as max(1, clog2(WIDTH)).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
a  in  WIDTH  operand A, captured on accepted start
b  in  WIDTH  operand B, captured on accepted start
cin  in  1  carry-in, captured on accepted start
busy  out  1  high while in RUN
done  out  1  one-cycle pulse when result is valid
sum  out  WIDTH  result, held until the next accepted start
cout  out  1  final carry, held with sum

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; sum=0, cout=0, busy=0, done=0; shift registers, carry register and counter all cleared.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - start=1 loads a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, sum_sh<=0, then moves to RUN.
  - start=0 stays in IDLE; sum and cout hold their values.
- RUN, every cycle:
  - Slice inputs are a_sh[0], b_sh[0], carry.
  - sum_sh <= {s_bit, sum_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1; carry <= c_bit; cnt <= cnt+1.
  - When cnt==WIDTH-1 on this edge, move to DONE.
  - busy=1 throughout RUN.
- DONE:
  - done=1 for exactly one cycle; sum=sum_sh and cout=carry are valid and registered.
  - Next state is always IDLE.
- Latency: start accepted at edge t → done high during the cycle after edge t+WIDTH, i.e. WIDTH+1 cycles after acceptance. Throughput is one operation per WIDTH+2 cycles.
- start while in RUN or DONE is ignored; it is not queued and operands are not re-sampled.
- Outputs: sum and cout update only when entering DONE and hold through IDLE. A new start does not clear them until the new DONE.
- WIDTH=1: RUN lasts one cycle; the counter stays at 0.
- Arithmetic is modulo 2^WIDTH with carry out to cout. No overflow flag.
- Reset during RUN or DONE aborts the operation: no done pulse, outputs return to reset values, and the next start is accepted normally.

Optional Feature:
Macro SERIAL_ADD_SUB_EN.
- Defined:
  - Adds port sub (in, 1), captured on accepted start.
  - When sub=1: b_sh loads ~b, carry loads 1 and cin is ignored. Result is a−b mod 2^WIDTH; cout=1 means no borrow.
  - When sub=0: behaviour is identical to the undefined case.
- Undefined: no sub port; addition only.

Decomposition:
- Package serial_add_pkg:
  - state typedef (IDLE=2'b00, RUN=2'b01, DONE=2'b10)
  - default WIDTH constant
- One sub-module fa_cell: purely combinational one-bit full adder (a, b, ci → s, co), instantiated once as the shared slice.
- The FSM, shift registers, counter and carry register live in serial_add_ctrl.

Test Plan:
1. fa_cell, all 8 input combinations → s = a^b^ci, co = majority(a,b,ci).
2. WIDTH=8, a=8'h0F, b=8'h01, cin=0, one-cycle start → busy for 8 cycles, done 9 cycles after start, sum=8'h10, cout=0. Then a=8'hFF, b=8'h01 → sum=8'h00, cout=1.
3. a=8'hAA, b=8'h55, cin=1 → sum=8'h00, cout=1. Hold start high across the whole operation → exactly one done pulse per WIDTH+2 cycles.
4. Start a=8'h03, b=8'h04; pulse start with a=8'hFF, b=8'hFF during RUN → ignored; result sum=8'h07, cout=0.
5. rst during the 4th RUN cycle → no done pulse; sum=0, cout=0, busy=0; a following start with a=8'h01, b=8'h01 → sum=8'h02.
6. SERIAL_ADD_SUB_EN defined: a=8'h05, b=8'h07, sub=1 → sum=8'hFE, cout=0; a=8'h07, b=8'h05, sub=1 → sum=8'h02, cout=1.
